rx_word_framer: RTL and testbench
=================================

RX_WORD_FRAMER -- requirements
Module: rx_word_framer

Interface
REQ-001 Parameter MAX_LEN, default 16: largest legal payload length, in 32-bit words.
REQ-002 Parameter TIMEOUT, default 8: consecutive valid_in-low cycles allowed mid-frame before abort.
REQ-003 clk_f  input  1  word clock, same clock as the PHY_RX 32-bit output.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 data_in  input  32  word from PHY_RX data_out.
REQ-006 valid_in  input  1  data_in qualifier, from PHY_RX valid_out.
REQ-007 data_out  output  32  forwarded payload word.
REQ-008 valid_out  output  1  data_out qualifier.
REQ-009 sop  output  1  high with the first payload word of a frame.
REQ-010 eop  output  1  high with the last payload word of a frame.
REQ-011 frame_ok  output  1  one-cycle pulse: trailer accepted and checksum matched.
REQ-012 frame_err  output  1  one-cycle pulse: frame aborted or checksum failed.
REQ-013 good_count  output  8  count of frame_ok pulses; wraps from 255 to 0.
REQ-014 err_count  output  8  count of frame_err pulses; saturates at 255.

Function
REQ-015 Frame format: header word, then L payload words, then trailer word.
- Header: [31:24]=8'hFB (STP), [23:16]=L, [15:0]=sequence number (ignored).
- Trailer: [31:24]=8'hFD (END), [23:0]=XOR of all L payload words, bits [23:0].
REQ-016 The FSM SHALL have three states, IDLE, PAYLOAD and TRAILER, and SHALL advance only on cycles where valid_in=1.
REQ-017 In IDLE, a word with [31:24]=FB and 1<=L<=MAX_LEN SHALL load the length counter, clear the checksum accumulator and go to PAYLOAD; every other valid word is discarded, including idle 32'hBCBCBCBC.
REQ-018 In IDLE, an FB header with L=0 or L>MAX_LEN SHALL pulse frame_err and remain in IDLE.
REQ-019 In PAYLOAD, each valid word SHALL be forwarded and XORed into the accumulator, whatever its content (an FB or FD byte is data here); after the L-th word the FSM goes to TRAILER.
REQ-020 Forwarding latency SHALL be exactly one cycle, registered; sop and eop are both high when L=1.
REQ-021 In TRAILER, a valid word with [31:24]=FD and [23:0] equal to the accumulator SHALL pulse frame_ok the next cycle; any other valid word SHALL pulse frame_err; both cases return to IDLE, and the word is not re-examined as a header.
REQ-022 In PAYLOAD or TRAILER, TIMEOUT consecutive cycles with valid_in=0 SHALL pulse frame_err and return to IDLE; any valid_in=1 resets the idle counter.
REQ-023 An abort SHALL NOT retract payload already forwarded; the consumer uses frame_err to discard it.
REQ-024 frame_ok and frame_err SHALL never be high in the same cycle.
REQ-025 valid_out, sop and eop SHALL be 0 whenever no payload word is forwarded; data_out holds its last value.

Reset
REQ-026 On reset=1 at a clk_f edge, the block SHALL return to IDLE and clear every output, counter and accumulator to 0.
REQ-027 Reset mid-frame SHALL abandon the frame without a frame_err pulse and without incrementing err_count.

Structure
REQ-028 A shared package SHALL hold the STP (8'hFB), END (8'hFD) and IDL (8'hBC) symbol constants and the state encoding.
REQ-029 The checksum SHALL live in one sub-module, rx_xor_accum, with clear, enable, 32-bit word in and 24-bit result out.

Verification
REQ-030 Header FB_03_0000, payload 1, 2, 4, trailer FD_000007 -> three words at 1-cycle latency, sop with 1, eop with 4, frame_ok pulse, good_count=1.
REQ-031 Same frame with trailer FD_000006 -> payload forwarded, frame_err pulse, err_count=1, good_count unchanged.
REQ-032 Header with L=0 and header with L=17 (MAX_LEN=16) -> a frame_err pulse for each, valid_out never asserted.
REQ-033 Header L=2, one payload word, then valid_in=0 for 8 cycles -> frame_err on timeout, then the next legal frame gives frame_ok.
REQ-034 Reset asserted after the second payload word of L=4 -> all outputs 0 the next cycle, no frame_err, the following legal frame gives frame_ok.
REQ-035 256 good frames -> good_count wraps to 0; 300 bad headers -> err_count holds at 255.

Source files
------------

// File: rtl/rx_word_framer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rx_word_framer_pkg
// Description : Framing symbols, widths and FSM state encoding shared by the
//               receive word framer and its checksum accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package rx_word_framer_pkg;

    localparam logic [7:0] c_stp = 8'hFB;
    localparam logic [7:0] c_end = 8'hFD;
    localparam logic [7:0] c_idl = 8'hBC;

    localparam int unsigned c_word_w = 32;
    localparam int unsigned c_csum_w = 24;
    localparam int unsigned c_len_w  = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_TRAILER = 2'd2
    } state_t;

    function automatic logic is_stp(input logic [c_word_w-1:0] w);
        return (w[31:24] == c_stp);
    endfunction

    function automatic logic is_end(input logic [c_word_w-1:0] w);
        return (w[31:24] == c_end);
    endfunction

    function automatic logic [c_len_w-1:0] hdr_len(input logic [c_word_w-1:0] w);
        return w[23:16];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rx_word_framer_if.sv
`default_nettype none
// ============================================================================
// Module      : rx_word_framer_if
// Description : Word stream from PHY_RX into the framer and the framed payload
//               stream and frame status out of it.
// Revision    : 1.0 - initial release
// ============================================================================
interface rx_word_framer_if;

    logic [31:0] data_in;
    logic        valid_in;
    logic [31:0] data_out;
    logic        valid_out;
    logic        sop;
    logic        eop;
    logic        frame_ok;
    logic        frame_err;
    logic [7:0]  good_count;
    logic [7:0]  err_count;

    // Framer side
    modport slave (
        input  data_in,
        input  valid_in,
        output data_out,
        output valid_out,
        output sop,
        output eop,
        output frame_ok,
        output frame_err,
        output good_count,
        output err_count
    );

    // PHY / consumer side
    modport master (
        output data_in,
        output valid_in,
        input  data_out,
        input  valid_out,
        input  sop,
        input  eop,
        input  frame_ok,
        input  frame_err,
        input  good_count,
        input  err_count
    );

endinterface
`default_nettype wire

// File: rtl/rx_xor_accum.sv
`default_nettype none
// ============================================================================
// Module      : rx_xor_accum
// Description : Running XOR of the low 24 bits of each enabled payload word.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_xor_accum
    import rx_word_framer_pkg::*;
(
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                clear,
    input  wire logic                enable,
    input  wire logic [c_word_w-1:0] word_in,
    output logic      [c_csum_w-1:0] result
);

    logic [c_csum_w-1:0] acc_q;
    logic [c_csum_w-1:0] acc_d;

    // Only the low 24 bits take part in the trailer checksum.
    logic unused_hi;
    assign unused_hi = ^word_in[c_word_w-1:c_csum_w];

    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (enable) begin
            acc_d = acc_q ^ word_in[c_csum_w-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign result = acc_q;

endmodule
`default_nettype wire

// File: rtl/rx_word_framer.sv
`default_nettype none
// ============================================================================
// Module      : rx_word_framer
// Description : Extracts STP/length-headed, END/checksum-trailed frames from the
//               PHY_RX word stream and forwards the payload with sop/eop.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_word_framer
    import rx_word_framer_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int TIMEOUT = 8
) (
    input  wire logic      clk_f,
    input  wire logic      reset,
    rx_word_framer_if.slave bus
);

    localparam int unsigned       c_idle_w    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_idle_w-1:0] c_idle_last = c_idle_w'(TIMEOUT - 1);

    state_t               state_q,     state_d;
    logic [c_len_w-1:0]   len_q,       len_d;
    logic                 first_q,     first_d;
    logic [c_idle_w-1:0]  idle_q,      idle_d;
    logic [c_word_w-1:0]  data_out_q,  data_out_d;
    logic                 valid_out_q, valid_out_d;
    logic                 sop_q,       sop_d;
    logic                 eop_q,       eop_d;
    logic                 ok_q,        ok_d;
    logic                 err_q,       err_d;
    logic [7:0]           good_q,      good_d;
    logic [7:0]           errc_q,      errc_d;

    logic                 acc_clear;
    logic                 acc_en;
    logic [c_csum_w-1:0]  acc_result;
    logic [c_len_w-1:0]   in_len;
    logic                 in_len_ok;

    rx_xor_accum u_accum (
        .clk     (clk_f),
        .rst     (reset),
        .clear   (acc_clear),
        .enable  (acc_en),
        .word_in (bus.data_in),
        .result  (acc_result)
    );

    assign in_len    = hdr_len(bus.data_in);
    assign in_len_ok = (in_len != '0) && (int'(in_len) <= MAX_LEN);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        first_d     = first_q;
        idle_d      = idle_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        sop_d       = 1'b0;
        eop_d       = 1'b0;
        ok_d        = 1'b0;
        err_d       = 1'b0;
        acc_clear   = 1'b0;
        acc_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                idle_d = '0;
                if (bus.valid_in && is_stp(bus.data_in)) begin
                    if (in_len_ok) begin
                        len_d     = in_len;
                        first_d   = 1'b1;
                        acc_clear = 1'b1;
                        state_d   = ST_PAYLOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_PAYLOAD: begin
                if (bus.valid_in) begin
                    idle_d      = '0;
                    valid_out_d = 1'b1;
                    data_out_d  = bus.data_in;
                    sop_d       = first_q;
                    eop_d       = (len_q == c_len_w'(1));
                    first_d     = 1'b0;
                    acc_en      = 1'b1;
                    len_d       = len_q - c_len_w'(1);
                    if (len_q == c_len_w'(1)) begin
                        state_d = ST_TRAILER;
                    end
                end
            end

            ST_TRAILER: begin
                // The trailer slot consumes the word whatever it holds.
                if (bus.valid_in) begin
                    idle_d  = '0;
                    state_d = ST_IDLE;
                    if (is_end(bus.data_in) && (bus.data_in[c_csum_w-1:0] == acc_result)) begin
                        ok_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Starvation watchdog while a frame is open.
        if ((state_q != ST_IDLE) && !bus.valid_in) begin
            if (idle_q == c_idle_last) begin
                err_d   = 1'b1;
                idle_d  = '0;
                state_d = ST_IDLE;
            end else begin
                idle_d = idle_q + c_idle_w'(1);
            end
        end

        good_d = good_q + {7'd0, ok_d};
        errc_d = (err_d && (errc_q != 8'hFF)) ? (errc_q + 8'd1) : errc_q;
    end

    always_ff @(posedge clk_f) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            first_q     <= 1'b0;
            idle_q      <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            ok_q        <= 1'b0;
            err_q       <= 1'b0;
            good_q      <= '0;
            errc_q      <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            first_q     <= first_d;
            idle_q      <= idle_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            ok_q        <= ok_d;
            err_q       <= err_d;
            good_q      <= good_d;
            errc_q      <= errc_d;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.valid_out  = valid_out_q;
    assign bus.sop        = sop_q;
    assign bus.eop        = eop_q;
    assign bus.frame_ok   = ok_q;
    assign bus.frame_err  = err_q;
    assign bus.good_count = good_q;
    assign bus.err_count  = errc_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_word_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_word_framer
// Description : Directed and randomized frame stimulus for rx_word_framer with
//               a frame-level reference model of the expected output stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_word_framer;
    import rx_word_framer_pkg::*;

    localparam int MAX_LEN = 16;
    localparam int TIMEOUT = 8;

    logic clk_f = 1'b0;
    logic reset;

    always #5 clk_f = ~clk_f;

    rx_word_framer_if bus ();

    rx_word_framer #(
        .MAX_LEN (MAX_LEN),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_f (clk_f),
        .reset (reset),
        .bus   (bus.slave)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_good = 0;
    int          exp_err  = 0;
    logic [31:0] exp_last = '0;
    logic [31:0] pay [0:255];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input logic fwd, input logic sop, input logic eop,
                                 input logic ok, input logic err);
        chk("valid_out",  32'(bus.valid_out),  32'(fwd));
        chk("sop",        32'(bus.sop),        32'(sop));
        chk("eop",        32'(bus.eop),        32'(eop));
        chk("data_out",   bus.data_out,        exp_last);
        chk("frame_ok",   32'(bus.frame_ok),   32'(ok));
        chk("frame_err",  32'(bus.frame_err),  32'(err));
        chk("ok_err_excl", 32'(bus.frame_ok & bus.frame_err), 32'd0);
        chk("good_count", 32'(bus.good_count), 32'(exp_good));
        chk("err_count",  32'(bus.err_count),  32'(exp_err));
    endtask

    // Present one word, then check what the framer shows one cycle later.
    task automatic cycle(input logic v, input logic [31:0] w, input logic fwd,
                         input logic sop, input logic eop, input logic ok, input logic err);
        bus.valid_in = v;
        bus.data_in  = w;
        @(posedge clk_f);
        #1;
        if (ok)  exp_good = (exp_good + 1) % 256;
        if (err && exp_err < 255) exp_err++;
        if (fwd) exp_last = w;
        check_outputs(fwd, sop, eop, ok, err);
    endtask

    task automatic reset_cycle();
        reset        = 1'b1;
        bus.valid_in = 1'b1;
        bus.data_in  = $urandom;
        @(posedge clk_f);
        #1;
        exp_good = 0;
        exp_err  = 0;
        exp_last = '0;
        check_outputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic gaps(input int gmax);
        int n;
        n = $urandom_range(0, gmax);
        repeat (n) cycle(1'b0, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic filler(input int n);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 2))
                0: cycle(1'b0, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                1: cycle(1'b1, {4{c_idl}}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                default: begin
                    w = $urandom;
                    if (w[31:24] == c_stp) w[31:24] = c_idl;
                    cycle(1'b1, w, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                end
            endcase
        end
    endtask

    function automatic logic [23:0] xor_sum(input int len);
        logic [23:0] s;
        s = '0;
        for (int i = 0; i < len; i++) s = s ^ pay[i][23:0];
        return s;
    endfunction

    // Header, pay[0..len-1] with optional gaps, then the given trailer word.
    task automatic send_frame(input int len, input logic [31:0] trailer, input int gmax);
        logic good;
        cycle(1'b1, {c_stp, 8'(len), 16'($urandom)}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < len; i++) begin
            gaps(gmax);
            cycle(1'b1, pay[i], 1'b1, (i == 0), (i == len - 1), 1'b0, 1'b0);
        end
        gaps(gmax);
        good = (trailer[31:24] == c_end) && (trailer[23:0] == xor_sum(len));
        cycle(1'b1, trailer, 1'b0, 1'b0, 1'b0, good, !good);
    endtask

    task automatic bad_header(input logic [7:0] len);
        cycle(1'b1, {c_stp, len, 16'($urandom)}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          len;
        logic [23:0] sum;
        logic [31:0] trl;

        reset        = 1'b1;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        repeat (2) @(posedge clk_f);
        #1;
        check_outputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        filler(6);

        // Reference frame 1,2,4 with matching and mismatching trailers.
        pay[0] = 32'd1; pay[1] = 32'd2; pay[2] = 32'd4;
        send_frame(3, 32'hFD00_0007, 0);
        chk("good_after_ok", 32'(bus.good_count), 32'd1);
        filler(3);
        send_frame(3, 32'hFD00_0006, 0);
        chk("err_after_bad_csum", 32'(bus.err_count), 32'd1);
        chk("good_unchanged", 32'(bus.good_count), 32'd1);

        // Illegal lengths.
        bad_header(8'd0);
        bad_header(8'd17);
        filler(2);

        // Starvation abort after one of two payload words.
        cycle(1'b1, {c_stp, 8'd2, 16'h1234}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'hFBFD_0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= TIMEOUT; i++)
            cycle(1'b0, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, (i == TIMEOUT));
        pay[0] = 32'hDEAD_BEEF; pay[1] = 32'h0BAD_F00D;
        send_frame(2, {c_end, xor_sum(2)}, 0);

        // Reset in the middle of an L=4 frame.
        cycle(1'b1, {c_stp, 8'd4, 16'h0001}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h1111_1111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h2222_2222, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_cycle();
        for (int i = 0; i < 4; i++) pay[i] = $urandom;
        send_frame(4, {c_end, xor_sum(4)}, 0);
        chk("good_after_reset", 32'(bus.good_count), 32'd1);

        // Randomized frames: lengths, gaps, corrupt or foreign trailers.
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, MAX_LEN);
            for (int i = 0; i < len; i++) pay[i] = $urandom;
            sum = xor_sum(len);
            case ($urandom_range(0, 3))
                0, 1:    trl = {c_end, sum};
                2:       trl = {c_end, sum ^ (24'd1 << $urandom_range(0, 23))};
                default: trl = {c_stp, 8'd2, 16'h0000};
            endcase
            send_frame(len, trl, 3);
            if ($urandom_range(0, 3) == 0) bad_header(8'($urandom_range(MAX_LEN + 1, 255)));
            filler($urandom_range(0, 3));
        end
        filler(2);

        // Counter wrap and saturation.
        for (int f = 0; f < 256; f++) begin
            pay[0] = $urandom;
            send_frame(1, {c_end, pay[0][23:0]}, 0);
        end
        for (int h = 0; h < 300; h++) bad_header(8'd0);
        chk("err_saturated", 32'(bus.err_count), 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
